// File: rtl/fpnew_pkg.sv
// Types shared between the FPU operation units and the result merge path.
package fpnew_pkg;

    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

    // Index width for a set of units; a single unit still needs one bit.
    function automatic int unsigned idx_width(input int unsigned num);
        return (num > 1) ? $clog2(num) : 1;
    endfunction

endpackage

// File: rtl/fpnew_rr_select.sv
// Round-robin request selector: finds the first set request at or above ptr,
// wrapping around, by rotating, priority-searching and un-rotating.
module fpnew_rr_select #(
    parameter int unsigned NumInputs = 4,
    parameter int unsigned IdxWidth  = fpnew_pkg::idx_width(NumInputs)
) (
    input  logic [NumInputs-1:0] req,
    input  logic [IdxWidth-1:0]  ptr,
    output logic                 any_req,
    output logic [IdxWidth-1:0]  gnt_idx
);

    assign any_req = |req;

    if (NumInputs == 1) begin : g_single
        logic unused_ptr;
        assign unused_ptr = ^ptr;
        assign gnt_idx    = '0;
    end else begin : g_multi
        localparam logic [IdxWidth:0] Num = NumInputs[IdxWidth:0];

        // Both operands are below NumInputs, so one conditional subtract wraps.
        function automatic logic [IdxWidth-1:0] wrap_add(input logic [IdxWidth-1:0] a,
                                                         input logic [IdxWidth-1:0] b);
            logic [IdxWidth:0] sum;
            sum = {1'b0, a} + {1'b0, b};
            if (sum >= Num) sum = sum - Num;
            return sum[IdxWidth-1:0];
        endfunction

        logic [NumInputs-1:0] rot;
        logic [IdxWidth-1:0]  off;

        always_comb begin
            for (int i = 0; i < NumInputs; i++) begin
                rot[i] = req[wrap_add(IdxWidth'(i), ptr)];
            end
        end

        always_comb begin
            off = '0;
            for (int i = NumInputs - 1; i >= 0; i--) begin
                if (rot[i]) off = IdxWidth'(i);
            end
        end

        assign gnt_idx = wrap_add(off, ptr);
    end

endmodule

// File: rtl/fpnew_out_arbiter.sv
// Merges the results of several FPU operation units into one registered
// output slot, granting one unit per cycle in round-robin order.
module fpnew_out_arbiter import fpnew_pkg::*; #(
    parameter int unsigned NumInputs = 4,
    parameter int unsigned Width     = 32,
    parameter type         TagType   = logic,
    localparam int unsigned IdxWidth = idx_width(NumInputs)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NumInputs-1:0] in_valid_i,
    output logic [NumInputs-1:0] in_ready_o,
    input  logic [Width-1:0]     result_i [NumInputs],
    input  status_t              status_i [NumInputs],
    input  logic [NumInputs-1:0] extension_bit_i,
    input  TagType               tag_i [NumInputs],
    input  logic                 flush_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [Width-1:0]     result_o,
    output status_t              status_o,
    output logic                 extension_bit_o,
    output TagType               tag_o,
    output logic [IdxWidth-1:0]  src_o,
    output logic                 busy_o
);

    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumInputs - 1);

    logic [IdxWidth-1:0] prio_q;
    logic [IdxWidth-1:0] gnt_idx;
    logic [IdxWidth-1:0] prio_next;
    logic                any_req;
    logic                slot_free;
    logic                grant_en;
    logic                xfer;

    logic                out_valid_q;
    logic [Width-1:0]    result_q;
    status_t             status_q;
    logic                ext_q;
    TagType              tag_q;
    logic [IdxWidth-1:0] src_q;

    logic [Width-1:0]    sel_result;
    status_t             sel_status;
    logic                sel_ext;
    TagType              sel_tag;

    fpnew_rr_select #(
        .NumInputs (NumInputs),
        .IdxWidth  (IdxWidth)
    ) i_rr_select (
        .req     (in_valid_i),
        .ptr     (prio_q),
        .any_req (any_req),
        .gnt_idx (gnt_idx)
    );

    // The slot can take new data when empty or when its result leaves this cycle.
    assign slot_free = ~out_valid_q | out_ready_i;
    assign grant_en  = any_req & slot_free & ~flush_i & ~rst_i;

    always_comb begin
        in_ready_o = '0;
        for (int i = 0; i < NumInputs; i++) begin
            in_ready_o[i] = grant_en & (gnt_idx == IdxWidth'(i));
        end
    end

    assign xfer = |(in_valid_i & in_ready_o);

    always_comb begin
        sel_result = '0;
        sel_status = '0;
        sel_ext    = 1'b0;
        sel_tag    = '0;
        for (int i = 0; i < NumInputs; i++) begin
            if (gnt_idx == IdxWidth'(i)) begin
                sel_result = result_i[i];
                sel_status = status_i[i];
                sel_ext    = extension_bit_i[i];
                sel_tag    = tag_i[i];
            end
        end
    end

    assign prio_next = (gnt_idx == LastIdx) ? '0 : gnt_idx + IdxWidth'(1);

    // Output slot: flush beats drain and refill; data only moves on a transfer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prio_q      <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            status_q    <= '0;
            ext_q       <= 1'b0;
            tag_q       <= '0;
            src_q       <= '0;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            prio_q      <= prio_next;
            result_q    <= sel_result;
            status_q    <= sel_status;
            ext_q       <= sel_ext;
            tag_q       <= sel_tag;
            src_q       <= gnt_idx;
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid_o     = out_valid_q;
    assign result_o        = result_q;
    assign status_o        = status_q;
    assign extension_bit_o = ext_q;
    assign tag_o           = tag_q;
    assign src_o           = src_q;
    assign busy_o          = out_valid_q | any_req;

endmodule

// File: tb/tb_fpnew_out_arbiter.sv
// Randomized and directed bench for fpnew_out_arbiter against a cycle-level
// reference model of the round-robin slot.
module tb_fpnew_out_arbiter;
    import fpnew_pkg::*;

    localparam int N = 4;
    typedef logic [3:0] tag_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0] in_valid, in_ready, ext_in;
    logic [31:0]  result_in [N];
    status_t      status_in [N];
    tag_t         tag_in [N];
    logic         flush, out_ready, out_valid, ext_out, busy;
    logic [31:0]  result_out;
    status_t      status_out;
    tag_t         tag_out;
    logic [1:0]   src;

    logic [0:0]   s_valid, s_ready, s_ext, s_src;
    logic [31:0]  s_result [1];
    status_t      s_status [1];
    tag_t         s_tag [1];
    logic         s_flush, s_out_ready, s_out_valid, s_ext_out, s_busy;
    logic [31:0]  s_result_out;
    status_t      s_status_out;
    tag_t         s_tag_out;

    fpnew_out_arbiter #(.NumInputs(N), .Width(32), .TagType(tag_t)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .result_i(result_in), .status_i(status_in), .extension_bit_i(ext_in), .tag_i(tag_in),
        .flush_i(flush), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .result_o(result_out), .status_o(status_out), .extension_bit_o(ext_out),
        .tag_o(tag_out), .src_o(src), .busy_o(busy)
    );

    fpnew_out_arbiter #(.NumInputs(1), .Width(32), .TagType(tag_t)) dut1 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(s_valid), .in_ready_o(s_ready),
        .result_i(s_result), .status_i(s_status), .extension_bit_i(s_ext), .tag_i(s_tag),
        .flush_i(s_flush), .out_valid_o(s_out_valid), .out_ready_i(s_out_ready),
        .result_o(s_result_out), .status_o(s_status_out), .extension_bit_o(s_ext_out),
        .tag_o(s_tag_out), .src_o(s_src), .busy_o(s_busy)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: what the output slot should hold and where the pointer is.
    int          m_ptr;
    bit          m_valid;
    logic [31:0] m_result;
    logic [4:0]  m_status;
    bit          m_ext;
    tag_t        m_tag;
    int          m_src;

    function automatic void model_reset();
        m_ptr = 0; m_valid = 0; m_result = '0; m_status = '0;
        m_ext = 0; m_tag = '0; m_src = 0;
    endfunction

    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            if (in_valid[2'((m_ptr + k) % N)]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r = '0;
        int g = model_grant();
        if (g >= 0 && !rst && !flush && !(m_valid && !out_ready)) r[2'(g)] = 1'b1;
        return r;
    endfunction

    task automatic check_outputs();
        check_eq("out_valid", 64'(out_valid), 64'(m_valid));
        check_eq("result", 64'(result_out), 64'(m_result));
        check_eq("status", 64'(status_out), 64'(m_status));
        check_eq("ext", 64'(ext_out), 64'(m_ext));
        check_eq("tag", 64'(tag_out), 64'(m_tag));
        check_eq("src", 64'(src), 64'(m_src));
    endtask

    task automatic cycle();
        logic [N-1:0] er;
        int g;
        logic [1:0] gi;
        #2;
        er = model_ready();
        g  = model_grant();
        check_eq("in_ready", 64'(in_ready), 64'(er));
        check_eq("busy", 64'(busy), 64'(m_valid || (|in_valid)));
        @(posedge clk);
        if (flush) begin
            m_valid = 0;
        end else if (er != '0) begin
            gi       = 2'(g);
            m_valid  = 1;
            m_result = result_in[gi];
            m_status = status_in[gi];
            m_ext    = ext_in[gi];
            m_tag    = tag_in[gi];
            m_src    = g;
            m_ptr    = (g + 1) % N;
        end else if (out_ready) begin
            m_valid = 0;
        end
        #1;
        check_outputs();
    endtask

    int rr_src [5]  = '{0, 1, 2, 3, 0};
    int wrap_src [3] = '{3, 0, 3};

    initial begin
        model_reset();
        in_valid = 4'b1111; flush = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            result_in[i] = 32'hA0 + 32'(i);
            status_in[i] = 5'(i + 1);
            tag_in[i]    = 4'(i + 8);
        end
        ext_in = 4'b1010;
        s_valid = 1'b0; s_ext = 1'b0; s_result[0] = '0; s_status[0] = '0;
        s_tag[0] = '0; s_flush = 1'b0; s_out_ready = 1'b1;

        // Reset held with all units requesting.
        #2;
        check_eq("rst_ready", 64'(in_ready), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(1));
        check_outputs();
        @(posedge clk); #1;
        check_eq("rst_ready2", 64'(in_ready), 64'(0));
        check_outputs();
        rst = 1'b0;
        #1;
        check_eq("rst_first_ready", 64'(in_ready), 64'(4'b0001));

        // Round-robin over all four units.
        for (int k = 0; k < 5; k++) begin
            cycle();
            check_eq("rr_src", 64'(src), 64'(rr_src[k]));
            check_eq("rr_result", 64'(result_out), 64'(32'hA0 + 32'(rr_src[k])));
        end

        // Backpressure after a grant to unit 2.
        in_valid = 4'b0100; result_in[2] = 32'h1234; tag_in[2] = 4'd5;
        cycle();
        check_eq("bp_src", 64'(src), 64'(2));
        in_valid = 4'b1111; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check_eq("bp_result", 64'(result_out), 64'(32'h1234));
            check_eq("bp_tag", 64'(tag_out), 64'(5));
            check_eq("bp_ready", 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        cycle();
        check_eq("bp_next_src", 64'(src), 64'(3));

        // Flush beats a simultaneous drain and refill.
        in_valid = 4'b0010; flush = 1'b1;
        #1;
        check_eq("flush_ready", 64'(in_ready), 64'(0));
        cycle();
        check_eq("flush_valid", 64'(out_valid), 64'(0));
        flush = 1'b0;
        cycle();
        check_eq("post_flush_src", 64'(src), 64'(1));
        check_eq("post_flush_valid", 64'(out_valid), 64'(1));

        // Pointer wrap between units 3 and 0.
        in_valid = 4'b0100;
        cycle();
        in_valid = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check_eq("wrap_src", 64'(src), 64'(wrap_src[k]));
        end

        // Asynchronous reset with a buffered result.
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("arst_valid", 64'(out_valid), 64'(0));
        check_eq("arst_ready", 64'(in_ready), 64'(0));
        check_outputs();
        @(posedge clk); #1;
        rst = 1'b0;

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            in_valid = 4'($urandom);
            ext_in   = 4'($urandom);
            for (int i = 0; i < N; i++) begin
                result_in[i] = $urandom;
                status_in[i] = 5'($urandom);
                tag_in[i]    = 4'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            cycle();
        end
        flush = 1'b0; in_valid = '0;

        // Single-input instance behaves as a one-slot register stage.
        check_eq("s_idle_valid", 64'(s_out_valid), 64'(0));
        check_eq("s_idle_busy", 64'(s_busy), 64'(0));
        for (int k = 1; k <= 3; k++) begin
            s_valid = 1'b1; s_result[0] = 32'(k);
            #2;
            check_eq("s_ready", 64'(s_ready), 64'(1));
            @(posedge clk); #1;
            check_eq("s_valid", 64'(s_out_valid), 64'(1));
            check_eq("s_result", 64'(s_result_out), 64'(k));
            check_eq("s_src", 64'(s_src), 64'(0));
            check_eq("s_busy", 64'(s_busy), 64'(1));
        end
        s_valid = 1'b0;
        #2;
        check_eq("s_busy_tail", 64'(s_busy), 64'(1));
        check_eq("s_ready_idle", 64'(s_ready), 64'(0));
        @(posedge clk); #1;
        check_eq("s_drained", 64'(s_out_valid), 64'(0));
        check_eq("s_busy_low", 64'(s_busy), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
